// File: rtl/exp_mod_pkg.sv
// exp_mod_pkg: shared width and state encoding for the modular exponentiation sequencer
package exp_mod_pkg;
  localparam int W = 192;
  typedef enum logic [2:0] {IDLE, SCAN, SQR, MUL, CONV, FIN} exp_state_t;
endpackage

// File: rtl/exp_mod_ctrl.sv
// exp_mod_ctrl: left-to-right square-and-multiply sequencer driving an external Montgomery multiplier
module exp_mod_ctrl #(
  parameter int W     = exp_mod_pkg::W,
  parameter int IDX_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] base_m,
  input  logic [W-1:0] one_m,
  input  logic [W-1:0] exponent,
  output logic [W-1:0] mm_x,
  output logic [W-1:0] mm_y,
  output logic         mm_start,
  input  logic [W-1:0] mm_z,
  input  logic         mm_done,
  output logic [W-1:0] result,
  output logic         done,
  output logic         busy
);
  import exp_mod_pkg::*;
  exp_state_t state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, e_q, e_d, x_q, x_d, y_q, y_d, res_q, res_d;
  logic go_q, go_d, last, bit_i;
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    a_d     = a_q;
    b_d     = b_q;
    e_d     = e_q;
    res_d   = res_q;
    last    = i_q == '0;
    bit_i   = e_q[i_q];
    case (state_q)
      IDLE: if (start) begin
        b_d     = base_m;
        e_d     = exponent;
        a_d     = one_m;
        i_d     = IDX_W'(W - 1);
        state_d = SCAN;
      end
      // look one bit ahead so the first set bit is reached without an extra scan cycle
      SCAN: if (bit_i) state_d = SQR;
        else if (last) state_d = CONV;
        else begin
          i_d     = i_q - 1'b1;
          state_d = e_q[i_d] ? SQR : SCAN;
        end
      SQR: if (mm_done) begin
        a_d = mm_z;
        if (bit_i) state_d = MUL;
        else if (last) state_d = CONV;
        else i_d = i_q - 1'b1;
      end
      MUL: if (mm_done) begin
        a_d     = mm_z;
        state_d = last ? CONV : SQR;
        i_d     = last ? i_q : i_q - 1'b1;
      end
      CONV: if (mm_done) begin
        res_d   = mm_z;
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a fresh visit to a multiply state, including SQR re-entering itself, issues one request
    go_d = (state_d == SQR || state_d == MUL || state_d == CONV) && (state_d != state_q || mm_done);
    x_d  = go_d ? a_d : x_q;
    y_d  = !go_d ? y_q : state_d == SQR ? a_d : state_d == MUL ? b_d : W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      e_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      a_q     <= a_d;
      b_q     <= b_d;
      e_q     <= e_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      go_q    <= go_d;
    end
  end
  assign mm_x     = x_q;
  assign mm_y     = y_q;
  assign mm_start = go_q;
  assign result   = res_q;
  assign done     = state_q == FIN;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_exp_mod_ctrl.sv
// tb_exp_mod_ctrl: directed checks of exp_mod_ctrl against a W=8, n=241 Montgomery multiplier stub
module tb_exp_mod_ctrl;
  logic clk = 1'b0, reset, start, mm_start, mm_done, done, busy;
  logic [7:0] base_m, one_m, exponent, mm_x, mm_y, mm_z, result;
  int errs = 0, checks = 0, nops = 0, lat;
  logic bok, sawdone;
  logic [7:0] xs [32];
  logic [7:0] ys [32];
  logic [2:0] lat_q = '0;
  logic [7:0] prod = '0;
  int ex [6] = '{15, 15, 45, 135, 10, 30};
  int ey [6] = '{15, 45, 45, 135, 45, 1};

  always #5 clk = ~clk;

  exp_mod_ctrl #(.W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_m(base_m), .one_m(one_m),
    .exponent(exponent), .mm_x(mm_x), .mm_y(mm_y), .mm_start(mm_start),
    .mm_z(mm_z), .mm_done(mm_done), .result(result), .done(done), .busy(busy)
  );

  // stub multiplier: x*y*R^-1 mod 241 with R^-1 = 225, done 4 cycles after start
  always @(posedge clk) begin
    if (mm_start) begin
      lat_q <= 3'd1;
      prod  <= 8'((int'(mm_x) * int'(mm_y) * 225) % 241);
    end else if (lat_q != 0) lat_q <= (lat_q == 3'd4) ? 3'd0 : lat_q + 3'd1;
  end
  assign mm_done = lat_q == 3'd4;
  assign mm_z    = prod;

  always @(negedge clk) if (mm_start) begin
    if (nops < 32) begin
      xs[nops] = mm_x;
      ys[nops] = mm_y;
    end
    nops++;
  end

  function automatic int modpow(int b, int e, int m);
    int r = 1;
    for (int k = 0; k < e; k++) r = (r * b) % m;
    return r;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [7:0] e, input logic [7:0] b, input int poke,
                    output int cyc, output logic busy_ok);
    exponent = e; base_m = b; one_m = 8'd15; start = 1'b1;
    nops = 0; busy_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    while (!done && cyc < 2000) begin
      busy_ok &= busy;
      if (cyc == poke) begin
        start = 1'b1; exponent = 8'hFF; base_m = 8'd99; one_m = 8'd7;
      end else begin
        start = 1'b0; exponent = e; base_m = b; one_m = 8'd15;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!done) check("timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_m = '0; one_m = '0; exponent = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst result", result, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);
    check("rst mm_start", mm_start, 0);
    check("rst mm_x", mm_x, 0);
    check("rst mm_y", mm_y, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    go(8'd0, 8'd45, -1, lat, bok);
    check("e0 latency", lat + 1, 15);
    check("e0 ops", nops, 1);
    check("e0 conv y", ys[0], 1);
    check("e0 conv x", xs[0], 15);
    check("e0 result", result, 1);
    @(posedge clk); #1;
    check("e0 done pulse", done, 0);
    check("e0 busy fall", busy, 0);

    go(8'd5, 8'd45, -1, lat, bok);
    check("e5 latency", lat + 1, 37);
    check("e5 ops", nops, 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("e5 x%0d", k), xs[k], ex[k]);
      check($sformatf("e5 y%0d", k), ys[k], ey[k]);
    end
    check("e5 result", result, 2);
    @(posedge clk); #1;

    go(8'hFF, 8'd45, -1, lat, bok);
    check("eff ops", nops, 17);
    check("eff result", result, modpow(3, 255, 241));
    check("eff busy", bok, 1);
    @(posedge clk); #1;

    go(8'd5, 8'd45, 8, lat, bok);
    check("poke ops", nops, 6);
    check("poke mul y", ys[1], 45);
    check("poke result", result, 2);
    @(posedge clk); #1;

    exponent = 8'd5; base_m = 8'd45; one_m = 8'd15; start = 1'b1; nops = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 200 && nops < 2; k++) begin
      @(posedge clk); #1;
    end
    check("rst wait mul", nops, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sawdone = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      sawdone |= done;
    end
    check("abort no done", sawdone, 0);
    check("abort busy", busy, 0);
    check("abort result", result, 0);
    check("abort mm_x", mm_x, 0);
    check("abort mm_y", mm_y, 0);
    check("abort mm_start", mm_start, 0);
    go(8'd5, 8'd45, -1, lat, bok);
    check("post abort result", result, 2);

    start = 1'b1; exponent = 8'd3; base_m = 8'd45; one_m = 8'd15;
    @(posedge clk); #1;
    check("fin start busy", busy, 0);
    check("held result", result, 2);
    check("idle done", done, 0);
    go(8'd3, 8'd45, -1, lat, bok);
    check("b2b ops", nops, 5);
    check("b2b result", result, 27);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
